// File: rtl/debounce_scheduler_if.sv
// Event handshake between the debounce scheduler (master) and its consumer (slave).
interface debounce_scheduler_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_ch;
    logic       evt_level;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_level,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_level,
        output evt_ready
    );
endinterface

// File: rtl/debounce_scheduler.sv
// Time-multiplexed debouncer: one shared engine visits a channel per scan cycle and
// queues clean-level changes as events delivered round-robin over a valid/ready port.
module debounce_scheduler #(
    parameter int unsigned       NUM_CH          = 8,
    parameter int unsigned       CNT_W           = 12,
    parameter logic [CNT_W-1:0]  DEBOUNCE_VISITS = 12'd500
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_scan_en,
    input  logic [NUM_CH-1:0]    i_noisy_in,
    output logic [NUM_CH-1:0]    o_clean_out,
    output logic                 o_overrun,
    debounce_scheduler_if.master evt
);

    localparam int unsigned      IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_t;

    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_rr;
    logic [NUM_CH-1:0] r_last;
    logic [NUM_CH-1:0] r_clean;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_pend_lvl;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic              r_overrun;
    out_state_t        r_state;
    out_state_t        w_state_nxt;
    logic [2:0]        r_evt_ch;
    logic              r_evt_level;

    logic              w_vis_in;
    logic              w_vis_last;
    logic [CNT_W-1:0]  w_vis_cnt;
    logic              w_vis_diff;
    logic              w_cnt_lt;
    logic              w_chg;
    logic [IDX_W-1:0]  w_ptr_nxt;

    logic              w_found;
    logic [IDX_W-1:0]  w_gnt;
    int unsigned       w_pos;
    logic              w_load;
    logic              w_grant;

    logic [NUM_CH-1:0] w_pend_nxt;
    logic [NUM_CH-1:0] w_lvl_nxt;
    logic              w_ovr_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_noisy_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_vis_in   = r_sync2[r_ptr];
    assign w_vis_last = r_last[r_ptr];
    assign w_vis_cnt  = r_cnt[r_ptr];
    assign w_vis_diff = (w_vis_in != w_vis_last);
    assign w_cnt_lt   = (w_vis_cnt < DEBOUNCE_VISITS);
    assign w_ptr_nxt  = (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;

    // A clean change happens only on a saturated visit whose stable level differs from clean_out.
    assign w_chg = i_scan_en && !w_vis_diff && !w_cnt_lt && (r_clean[r_ptr] != w_vis_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_last  <= '0;
            r_clean <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_scan_en) begin
            r_ptr <= w_ptr_nxt;
            if (w_vis_diff) begin
                r_cnt[r_ptr]  <= '0;
                r_last[r_ptr] <= w_vis_in;
            end else if (w_cnt_lt) begin
                r_cnt[r_ptr] <= w_vis_cnt + 1'b1;
            end else begin
                r_clean[r_ptr] <= w_vis_last;
            end
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_pos   = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            w_pos = 32'(r_rr) + i;
            if (w_pos >= NUM_CH) begin
                w_pos = w_pos - NUM_CH;
            end
            if (!w_found && r_pend[IDX_W'(w_pos)]) begin
                w_found = 1'b1;
                w_gnt   = IDX_W'(w_pos);
            end
        end
    end

    assign w_load  = (r_state == OUT_EMPTY) || evt.evt_ready;
    assign w_grant = w_load && w_found;

    // Grant reads the registered level, so a same-cycle change on the granted channel re-arms pend.
    always_comb begin
        w_pend_nxt = r_pend;
        w_lvl_nxt  = r_pend_lvl;
        w_ovr_set  = 1'b0;
        if (w_grant) begin
            w_pend_nxt[w_gnt] = 1'b0;
        end
        if (w_chg) begin
            if (r_pend[r_ptr] && !(w_grant && (w_gnt == r_ptr))) begin
                w_ovr_set = 1'b1;
            end
            w_pend_nxt[r_ptr] = 1'b1;
            w_lvl_nxt[r_ptr]  = w_vis_last;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= '0;
            r_pend_lvl <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_lvl <= w_lvl_nxt;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = w_found ? OUT_FULL : OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_ch    <= '0;
            r_evt_level <= 1'b0;
            r_rr        <= LAST_CH;
        end else if (w_grant) begin
            r_evt_ch    <= 3'(w_gnt);
            r_evt_level <= r_pend_lvl[w_gnt];
            r_rr        <= w_gnt;
        end
    end

    assign evt.evt_valid = (r_state == OUT_FULL);
    assign evt.evt_ch    = r_evt_ch;
    assign evt.evt_level = r_evt_level;
    assign o_clean_out   = r_clean;
    assign o_overrun     = r_overrun;

endmodule
